// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage for the single-cycle RV32 core.
// Owns the PC, issues valid/ready requests to instruction memory, holds each
// fetched instruction stable for the control unit until it retires, and then
// forms the next PC from pc_sel, the branch outcome and the offsets.
//
// Ports:
//   clk, rst                       core clock, synchronous active-high reset
//   pc_sel, branch_taken           next-PC select and BEQ outcome
//   br_offset, jmp_offset          sign-extended byte offsets
//   imem_req_valid/ready/addr      fetch request channel
//   imem_rsp_valid/data            fetch response channel
//   instr_valid/ready              handshake with the core for the held instr
//   instr, pc, opcode, funct3      held instruction, its PC and decode slices
//   misalign                       sticky: a computed next PC was not word aligned

package fetch_unit_pkg;

  typedef enum logic [1:0] {
    PC_4   = 2'd0,
    PC_BEQ = 2'd1,
    PC_J   = 2'd2
  } PC_sel_e;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_I      = 7'h13,
    OP_AUIPC  = 7'h17,
    OP_STORE  = 7'h23,
    OP_R      = 7'h33,
    OP_LUI    = 7'h37,
    OP_BRANCH = 7'h63,
    OP_JAL    = 7'h6F
  } opcode_e;

  typedef enum logic [2:0] {
    F3_0 = 3'd0,
    F3_1 = 3'd1,
    F3_2 = 3'd2,
    F3_3 = 3'd3,
    F3_4 = 3'd4,
    F3_5 = 3'd5,
    F3_6 = 3'd6,
    F3_7 = 3'd7
  } funct3_e;

endpackage

// state  | meaning
// S_REQ  | request pending on imem, address held at pc
// S_WAIT | request accepted, waiting for response data
// S_HOLD | instruction held and valid, waiting for core to retire it
// S_HALT | misaligned next PC computed; idle until reset
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  PC_sel_e         pc_sel,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] br_offset,
  input  logic [XLEN-1:0] jmp_offset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output opcode_e         opcode,
  output funct3_e         funct3,
  output logic            misalign
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_e;

  state_e          state, state_nxt;
  logic [XLEN-1:0] pc_q;
  logic [ILEN-1:0] instr_q;
  logic            misalign_q;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] pc_plus4;
  logic            retire;
  logic            next_misaligned;

  assign pc_plus4        = pc_q + XLEN'(4);
  assign retire          = (state == S_HOLD) && instr_ready;
  assign next_misaligned = |next_pc[1:0];

  always_comb begin
    next_pc = pc_plus4;
    case (pc_sel)
      PC_4:    next_pc = pc_plus4;
      PC_BEQ:  next_pc = branch_taken ? (pc_q + br_offset) : pc_plus4;
      PC_J:    next_pc = pc_q + jmp_offset;
      default: next_pc = pc_plus4;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:  if (imem_req_ready) state_nxt = S_WAIT;
      S_WAIT: if (imem_rsp_valid) state_nxt = S_HOLD;
      S_HOLD: if (instr_ready)    state_nxt = next_misaligned ? S_HALT : S_REQ;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_REQ;
    endcase
  end

  // Outputs; the request is masked by rst so nothing is offered while in reset
  always_comb begin
    imem_req_valid = (state == S_REQ) && !rst;
    imem_req_addr  = pc_q;
    instr_valid    = (state == S_HOLD);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      if (state == S_WAIT && imem_rsp_valid) instr_q <= imem_rsp_data;
      if (retire) pc_q <= next_pc;
      if (retire && next_misaligned) misalign_q <= 1'b1;
    end
  end

  assign instr    = instr_q;
  assign pc       = pc_q;
  assign misalign = misalign_q;
  assign opcode   = opcode_e'(instr_q[6:0]);
  assign funct3   = funct3_e'(instr_q[14:12]);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a table of directed fetch/retire
// records, hand-written reset/halt sequences, then randomized traffic
// checked against an arithmetic next-PC model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  PC_sel_e     pc_sel;
  logic        branch_taken;
  logic [31:0] br_offset, jmp_offset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, pc;
  opcode_e     opcode;
  funct3_e     funct3;
  logic        misalign;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .ILEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .pc_sel(pc_sel), .branch_taken(branch_taken),
    .br_offset(br_offset), .jmp_offset(jmp_offset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .pc(pc), .opcode(opcode),
    .funct3(funct3), .misalign(misalign)
  );

  typedef struct {
    logic [1:0]  sel;
    logic        taken;
    logic [31:0] br;
    logic [31:0] jmp;
    logic [31:0] data;
    int          req_d;
    int          rsp_d;
    int          hold;
    logic [31:0] exp_next;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [1:0] sel,
                                             input logic taken, input logic [31:0] br,
                                             input logic [31:0] jmp);
    longint unsigned sum;
    if (sel == 2'd1 && taken)  sum = longint'(cur) + longint'(br);
    else if (sel == 2'd2)      sum = longint'(cur) + longint'(jmp);
    else                       sum = longint'(cur) + 4;
    return sum[31:0];
  endfunction

  // Entered at posedge+1 with the DUT expected in the request state.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                       input int req_d, input int rsp_d);
    for (int i = 0; i < req_d; i++) begin
      check("req_valid_stall", {31'b0, imem_req_valid}, 32'd1);
      check("req_addr_stall", imem_req_addr, exp_addr);
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~data;
      step();
    end
    imem_rsp_valid = 1'b0;
    check("req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("req_addr", imem_req_addr, exp_addr);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("req_valid_drop", {31'b0, imem_req_valid}, 32'd0);
    for (int i = 0; i < rsp_d; i++) step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    step();
    imem_rsp_valid = 1'b0;
    check("instr_valid", {31'b0, instr_valid}, 32'd1);
    check("instr", instr, data);
    check("pc", pc, exp_addr);
    check("opcode", {25'b0, opcode}, {25'b0, data[6:0]});
    check("funct3", {29'b0, funct3}, {29'b0, data[14:12]});
  endtask

  task automatic retire(input logic [1:0] sel, input logic taken, input logic [31:0] br,
                        input logic [31:0] jmp, input int hold,
                        input logic [31:0] exp_data, input logic [31:0] exp_pc);
    for (int i = 0; i < hold; i++) begin
      instr_ready    = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom;
      pc_sel         = PC_sel_e'(2'($urandom_range(0, 3)));
      step();
      check("hold_instr", instr, exp_data);
      check("hold_pc", pc, exp_pc);
      check("hold_valid", {31'b0, instr_valid}, 32'd1);
    end
    imem_rsp_valid = 1'b0;
    pc_sel         = PC_sel_e'(sel);
    branch_taken   = taken;
    br_offset      = br;
    jmp_offset     = jmp;
    instr_ready    = 1'b1;
    step();
    instr_ready = 1'b0;
    check("retire_valid_drop", {31'b0, instr_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    check("rst_req_forced_low", {31'b0, imem_req_valid}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("post_rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("post_rst_addr", imem_req_addr, 32'h0);
    check("post_rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("post_rst_misalign", {31'b0, misalign}, 32'd0);
  endtask

  task automatic check_halt(input logic [31:0] exp_pc);
    check("halt_misalign", {31'b0, misalign}, 32'd1);
    check("halt_pc", pc, exp_pc);
    for (int i = 0; i < 10; i++) begin
      instr_ready    = 1'b1;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b1;
      step();
      check("halt_no_req", {31'b0, imem_req_valid}, 32'd0);
      check("halt_no_instr", {31'b0, instr_valid}, 32'd0);
    end
    instr_ready    = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
  endtask

  logic [6:0] ops[8] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h6F};

  initial begin
    logic [31:0] exp_pc, nxt, data, br, jmp;
    logic [1:0]  sel;
    logic        taken;
    int          rd, sd, hd;

    //          sel  tk   br            jmp           data          rq rs hd  next
    tbl[0]  = '{2'd0, 1'b0, 32'h0,        32'h0,        32'h0000_0033, 0, 0, 0, 32'h0000_0004};
    tbl[1]  = '{2'd2, 1'b0, 32'h0,        32'h4,        32'h00A0_0093, 0, 1, 0, 32'h0000_0008};
    tbl[2]  = '{2'd2, 1'b0, 32'h0,        32'h8,        32'h0000_A283, 3, 0, 0, 32'h0000_0010};
    tbl[3]  = '{2'd1, 1'b1, 32'hFFFF_FFF8, 32'h0,       32'hFE20_8EE3, 0, 0, 4, 32'h0000_0008};
    tbl[4]  = '{2'd2, 1'b0, 32'h0,        32'h8,        32'h0040_006F, 1, 2, 0, 32'h0000_0010};
    tbl[5]  = '{2'd1, 1'b0, 32'hFFFF_FFF8, 32'h0,       32'hFE20_8EE3, 0, 0, 4, 32'h0000_0014};
    tbl[6]  = '{2'd2, 1'b0, 32'h0,        32'hC,        32'h0000_12B7, 0, 0, 0, 32'h0000_0020};
    tbl[7]  = '{2'd2, 1'b0, 32'h0,        32'h100,      32'h0000_1017, 0, 0, 1, 32'h0000_0120};
    tbl[8]  = '{2'd2, 1'b0, 32'h0,        32'hFFFF_FEDC, 32'h0020_A023, 0, 0, 0, 32'hFFFF_FFFC};
    tbl[9]  = '{2'd0, 1'b0, 32'h0,        32'h0,        32'h4000_5033, 0, 0, 0, 32'h0000_0000};
    tbl[10] = '{2'd3, 1'b1, 32'h8,        32'h8,        32'h0000_7013, 0, 0, 0, 32'h0000_0004};
    tbl[11] = '{2'd1, 1'b0, 32'h3,        32'h1,        32'h0000_0063, 0, 0, 0, 32'h0000_0008};
    tbl[12] = '{2'd1, 1'b1, 32'h38,       32'h0,        32'h0000_6063, 0, 0, 0, 32'h0000_0040};

    rst = 1'b1; pc_sel = PC_4; branch_taken = 1'b0; br_offset = '0; jmp_offset = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; instr_ready = 1'b0;
    step();
    check("reset_instr", instr, 32'h0);
    check("reset_pc", pc, 32'h0);
    do_reset();

    exp_pc = 32'h0;
    foreach (tbl[i]) begin
      fetch(exp_pc, tbl[i].data, tbl[i].req_d, tbl[i].rsp_d);
      retire(tbl[i].sel, tbl[i].taken, tbl[i].br, tbl[i].jmp, tbl[i].hold, tbl[i].data, exp_pc);
      check("next_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("next_req_addr", imem_req_addr, tbl[i].exp_next);
      exp_pc = tbl[i].exp_next;
    end

    // Misaligned jump from 0x40 halts the fetch stage.
    fetch(32'h40, 32'h0060_006F, 0, 0);
    retire(2'd2, 1'b0, 32'h0, 32'h6, 0, 32'h0060_006F, 32'h40);
    check_halt(32'h46);
    do_reset();

    // Reset while a request is outstanding.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("wait_rst_req_low", {31'b0, imem_req_valid}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("wait_rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("wait_rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("wait_rst_addr", imem_req_addr, 32'h0);
    fetch(32'h0, 32'h0000_0033, 0, 0);
    retire(2'd0, 1'b0, 32'h0, 32'h0, 0, 32'h0000_0033, 32'h0);
    check("wait_rst_next_addr", imem_req_addr, 32'h4);
    do_reset();

    // Randomized traffic against the next-PC model.
    exp_pc = 32'h0;
    for (int n = 0; n < 300; n++) begin
      data  = {$urandom} & 32'hFFFF_FF80;
      data  = data | {25'b0, ops[$urandom_range(0, 7)]};
      rd    = $urandom_range(0, 2);
      sd    = $urandom_range(0, 2);
      hd    = $urandom_range(0, 2);
      sel   = 2'($urandom_range(0, 3));
      taken = 1'($urandom_range(0, 1));
      br    = $urandom;
      jmp   = $urandom;
      if ($urandom_range(0, 15) != 0) begin
        br  = br & 32'hFFFF_FFFC;
        jmp = jmp & 32'hFFFF_FFFC;
      end
      nxt = model_next(exp_pc, sel, taken, br, jmp);
      fetch(exp_pc, data, rd, sd);
      retire(sel, taken, br, jmp, hd, data, exp_pc);
      if (nxt[1:0] != 2'b00) begin
        check_halt(nxt);
        do_reset();
        exp_pc = 32'h0;
      end else begin
        check("rand_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("rand_req_addr", imem_req_addr, nxt);
        exp_pc = nxt;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
